// File: rtl/sprite_anim_fetch.sv
// Sprite animation sequencer and two-stage pixel fetch for one fighter.
// Steps the action/frame on frame ticks and turns raster positions into ROM row reads and opaque flags.
module sprite_anim_fetch #(
    parameter int SPR_W       = 16,
    parameter int SPR_H       = 16,
    parameter int ACT_BITS    = 3,
    parameter int FRM_BITS    = 3,
    parameter int NUM_FRAMES  = 4,
    parameter int FRAME_HOLD  = 8,
    parameter int SCALE_SHIFT = 2,
    parameter logic [(1<<ACT_BITS)-1:0] ONESHOT_MASK = 8'b00011000,
    parameter int COORD_W     = 10
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic                                           frame_tick,
    input  logic                                           act_req,
    input  logic [ACT_BITS-1:0]                            act_code,
    output logic                                           act_busy,
    input  logic                                           facing_left,
    input  logic [COORD_W-1:0]                             pos_x,
    input  logic [COORD_W-1:0]                             pos_y,
    input  logic [COORD_W-1:0]                             hcount,
    input  logic [COORD_W-1:0]                             vcount,
    input  logic                                           pix_valid,
    output logic [$clog2(SPR_H)+ACT_BITS+FRM_BITS-1:0]     rom_addr,
    input  logic [SPR_W-1:0]                               rom_data,
    output logic                                           pix_on,
    output logic                                           pix_valid_o,
    output logic [ACT_BITS-1:0]                            cur_action,
    output logic [FRM_BITS-1:0]                            cur_frame
);

    localparam int ROW_W  = $clog2(SPR_H);
    localparam int COL_W  = $clog2(SPR_W);
    localparam int HOLD_W = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;

    localparam logic [HOLD_W-1:0]   LAST_HOLD = HOLD_W'(FRAME_HOLD - 1);
    localparam logic [FRM_BITS-1:0] LAST_FRM  = FRM_BITS'(NUM_FRAMES - 1);
    localparam logic [COORD_W-1:0]  BOX_W     = COORD_W'(SPR_W << SCALE_SHIFT);
    localparam logic [COORD_W-1:0]  BOX_H     = COORD_W'(SPR_H << SCALE_SHIFT);

    typedef enum logic [0:0] {
        LOOP    = 1'b0,
        ONESHOT = 1'b1
    } state_t;

    state_t             state;
    logic [HOLD_W-1:0]  hold;

    // Unmirrored column 0 is the ROM word's MSB; mirroring reads the word LSB-first.
    function automatic logic [COL_W-1:0] bit_index(input logic [COL_W-1:0] col,
                                                   input logic             mirror);
        return mirror ? col : (COL_W'(SPR_W - 1) - col);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= LOOP;
            cur_action <= '0;
            cur_frame  <= '0;
            hold       <= '0;
            act_busy   <= 1'b0;
        end else begin
            case (state)
                LOOP: begin
                    // An accepted request swallows a coincident tick.
                    if (act_req && (act_code != cur_action)) begin
                        cur_action <= act_code;
                        cur_frame  <= '0;
                        hold       <= '0;
                        if (ONESHOT_MASK[act_code]) begin
                            state    <= ONESHOT;
                            act_busy <= 1'b1;
                        end
                    end else if (frame_tick) begin
                        if (hold == LAST_HOLD) begin
                            hold      <= '0;
                            cur_frame <= (cur_frame == LAST_FRM) ? '0 : cur_frame + 1'b1;
                        end else begin
                            hold <= hold + 1'b1;
                        end
                    end
                end
                ONESHOT: begin
                    if (frame_tick) begin
                        if (hold == LAST_HOLD) begin
                            hold <= '0;
                            if (cur_frame == LAST_FRM) begin
                                state      <= LOOP;
                                cur_action <= '0;
                                cur_frame  <= '0;
                                act_busy   <= 1'b0;
                            end else begin
                                cur_frame <= cur_frame + 1'b1;
                            end
                        end else begin
                            hold <= hold + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= LOOP;
                end
            endcase
        end
    end

    // Stage 0: sprite-relative offsets; wrapped negatives land outside the box.
    logic [COORD_W-1:0] dx_p0;
    logic [COORD_W-1:0] dy_p0;
    logic               in_box_p0;

    always_comb begin
        dx_p0     = hcount - pos_x;
        dy_p0     = vcount - pos_y;
        in_box_p0 = pix_valid && (dx_p0 < BOX_W) && (dy_p0 < BOX_H);
    end

    // Stage 1: ROM row address issued, column and qualifiers held for the returning word.
    logic [COL_W-1:0] col_p1;
    logic             in_box_p1;
    logic             face_p1;
    logic             vld_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            rom_addr  <= '0;
            col_p1    <= '0;
            in_box_p1 <= 1'b0;
            face_p1   <= 1'b0;
            vld_p1    <= 1'b0;
        end else begin
            rom_addr  <= {dy_p0[SCALE_SHIFT +: ROW_W], cur_action, cur_frame};
            col_p1    <= dx_p0[SCALE_SHIFT +: COL_W];
            in_box_p1 <= in_box_p0;
            face_p1   <= facing_left;
            vld_p1    <= pix_valid;
        end
    end

    // Stage 2: a cleared ROM bit marks body pixels.
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_on      <= 1'b0;
            pix_valid_o <= 1'b0;
        end else begin
            pix_on      <= in_box_p1 && !rom_data[bit_index(col_p1, face_p1)];
            pix_valid_o <= vld_p1;
        end
    end

endmodule

// File: tb/tb_sprite_anim_fetch.sv
// Bench for sprite_anim_fetch: directed sequences, a pixel vector table and randomized traffic
// checked against a tick-count animation model and an arithmetic pixel model.
module tb_sprite_anim_fetch;

    localparam int SPR_W       = 16;
    localparam int SPR_H       = 16;
    localparam int ACT_BITS    = 3;
    localparam int FRM_BITS    = 3;
    localparam int NUM_FRAMES  = 4;
    localparam int FRAME_HOLD  = 8;
    localparam int SCALE_SHIFT = 2;
    localparam int COORD_W     = 10;
    localparam logic [7:0] ONESHOT_MASK = 8'b00011000;

    logic                clk = 1'b0;
    logic                rst;
    logic                frame_tick;
    logic                act_req;
    logic [2:0]          act_code;
    logic                act_busy;
    logic                facing_left;
    logic [9:0]          pos_x, pos_y, hcount, vcount;
    logic                pix_valid;
    logic [9:0]          rom_addr;
    logic [15:0]         rom_data;
    logic                pix_on;
    logic                pix_valid_o;
    logic [2:0]          cur_action;
    logic [2:0]          cur_frame;

    logic                rom_mode;
    logic [15:0]         fixed_word;

    always #5 clk = ~clk;

    sprite_anim_fetch #(
        .SPR_W(SPR_W), .SPR_H(SPR_H), .ACT_BITS(ACT_BITS), .FRM_BITS(FRM_BITS),
        .NUM_FRAMES(NUM_FRAMES), .FRAME_HOLD(FRAME_HOLD), .SCALE_SHIFT(SCALE_SHIFT),
        .ONESHOT_MASK(ONESHOT_MASK), .COORD_W(COORD_W)
    ) dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .act_req(act_req),
        .act_code(act_code), .act_busy(act_busy), .facing_left(facing_left),
        .pos_x(pos_x), .pos_y(pos_y), .hcount(hcount), .vcount(vcount),
        .pix_valid(pix_valid), .rom_addr(rom_addr), .rom_data(rom_data),
        .pix_on(pix_on), .pix_valid_o(pix_valid_o), .cur_action(cur_action),
        .cur_frame(cur_frame)
    );

    function automatic logic [15:0] rom_hash(input logic [9:0] a);
        logic [31:0] h;
        h = {22'd0, a} * 32'd40503 + 32'h1234;
        return h[23:8] ^ {a[5:0], a};
    endfunction

    // Asynchronous-read ROM: the word for the registered address is ready by the next edge.
    always_comb rom_data = rom_mode ? fixed_word : rom_hash(rom_addr);

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: action, ticks since the action started, one-shot flag.
    int m_act, m_ticks;
    bit m_busy;
    bit e1_on, e1_vld, e1_in, e2_on, e2_vld;
    int e1_addr;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        int dx, dy, col, row, bitn, addr;
        bit in_b, on_b;
        logic [15:0] w;
        dx   = (int'(hcount) - int'(pos_x)) & 1023;
        dy   = (int'(vcount) - int'(pos_y)) & 1023;
        in_b = pix_valid && (dx < SPR_W * (1 << SCALE_SHIFT)) && (dy < SPR_H * (1 << SCALE_SHIFT));
        row  = (dy / (1 << SCALE_SHIFT)) % SPR_H;
        col  = (dx / (1 << SCALE_SHIFT)) % SPR_W;
        addr = row * 64 + m_act * 8 + m_ticks / FRAME_HOLD;
        w    = rom_mode ? fixed_word : rom_hash(addr[9:0]);
        bitn = facing_left ? col : SPR_W - 1 - col;
        on_b = in_b && (w[bitn] == 1'b0);
        @(posedge clk);
        #1;
        if (rst) begin
            m_act = 0; m_ticks = 0; m_busy = 0;
            e1_on = 0; e1_vld = 0; e1_in = 0; e2_on = 0; e2_vld = 0; e1_addr = 0;
        end else begin
            if (!m_busy && act_req && int'(act_code) != m_act) begin
                m_act   = int'(act_code);
                m_ticks = 0;
                m_busy  = ONESHOT_MASK[act_code];
            end else if (frame_tick) begin
                m_ticks++;
                if (m_ticks == NUM_FRAMES * FRAME_HOLD) begin
                    m_ticks = 0;
                    if (m_busy) begin
                        m_busy = 0;
                        m_act  = 0;
                    end
                end
            end
            e2_on = e1_on; e2_vld = e1_vld;
            e1_on = on_b;  e1_vld = pix_valid; e1_in = in_b; e1_addr = addr;
        end
        check("model_action", int'(cur_action), m_act);
        check("model_frame", int'(cur_frame), m_ticks / FRAME_HOLD);
        check("model_busy", int'(act_busy), int'(m_busy));
        check("model_pix_on", int'(pix_on), int'(e2_on));
        check("model_pix_valid_o", int'(pix_valid_o), int'(e2_vld));
        if (e1_in) check("model_rom_addr", int'(rom_addr), e1_addr);
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            frame_tick = 1'b1; step();
            frame_tick = 1'b0; step();
        end
    endtask

    typedef struct {
        logic [15:0] word;
        logic        face;
        int          hx;
        logic        exp_on;
    } vec_t;

    vec_t vecs[20];

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = '{16'hFC3F, 1'b0, 121, 1'b0};
        vecs[1]  = '{16'hFC3F, 1'b0, 125, 1'b1};
        vecs[2]  = '{16'hFC3F, 1'b0, 137, 1'b1};
        vecs[3]  = '{16'hFC3F, 1'b0, 141, 1'b0};
        vecs[4]  = '{16'hFC3F, 1'b1, 121, 1'b0};
        vecs[5]  = '{16'hFC3F, 1'b1, 125, 1'b1};
        vecs[6]  = '{16'hFC3F, 1'b1, 137, 1'b1};
        vecs[7]  = '{16'hFC3F, 1'b1, 141, 1'b0};
        vecs[8]  = '{16'hF807, 1'b0, 117, 1'b0};
        vecs[9]  = '{16'hF807, 1'b0, 121, 1'b1};
        vecs[10] = '{16'hF807, 1'b0, 149, 1'b1};
        vecs[11] = '{16'hF807, 1'b0, 153, 1'b0};
        vecs[12] = '{16'hF807, 1'b1, 109, 1'b0};
        vecs[13] = '{16'hF807, 1'b1, 113, 1'b1};
        vecs[14] = '{16'hF807, 1'b1, 141, 1'b1};
        vecs[15] = '{16'hF807, 1'b1, 145, 1'b0};
        vecs[16] = '{16'h0000, 1'b0,  99, 1'b0};
        vecs[17] = '{16'h0000, 1'b0, 100, 1'b1};
        vecs[18] = '{16'h0000, 1'b0, 163, 1'b1};
        vecs[19] = '{16'h0000, 1'b0, 164, 1'b0};

        rst = 1'b1; frame_tick = 1'b0; act_req = 1'b0; act_code = 3'd0;
        facing_left = 1'b0; pos_x = 10'd100; pos_y = 10'd50;
        hcount = 10'd0; vcount = 10'd0; pix_valid = 1'b0;
        rom_mode = 1'b0; fixed_word = 16'h0000;
        m_act = 0; m_ticks = 0; m_busy = 0;
        e1_on = 0; e1_vld = 0; e1_in = 0; e2_on = 0; e2_vld = 0; e1_addr = 0;

        step(); step();
        check("reset_action", int'(cur_action), 0);
        check("reset_frame", int'(cur_frame), 0);
        check("reset_busy", int'(act_busy), 0);
        check("reset_rom_addr", int'(rom_addr), 0);
        check("reset_pix_on", int'(pix_on), 0);
        check("reset_pix_valid_o", int'(pix_valid_o), 0);
        rst = 1'b0;
        step();

        // Looping frame cadence over 40 ticks.
        ticks(7);  check("loop_frame_t7", int'(cur_frame), 0);
        ticks(1);  check("loop_frame_t8", int'(cur_frame), 1);
        ticks(8);  check("loop_frame_t16", int'(cur_frame), 2);
        ticks(8);  check("loop_frame_t24", int'(cur_frame), 3);
        ticks(8);  check("loop_frame_t32", int'(cur_frame), 0);
        check("loop_busy", int'(act_busy), 0);
        ticks(8);  check("loop_frame_t40", int'(cur_frame), 1);

        // One-shot punch with a dropped kick request.
        act_req = 1'b1; act_code = 3'd3; step(); act_req = 1'b0;
        check("punch_busy", int'(act_busy), 1);
        check("punch_action", int'(cur_action), 3);
        check("punch_frame", int'(cur_frame), 0);
        for (int k = 1; k <= 32; k++) begin
            frame_tick = 1'b1; step(); frame_tick = 1'b0;
            if (k == 10) begin
                act_req = 1'b1; act_code = 3'd4; step(); act_req = 1'b0;
                check("punch_ignore_kick", int'(cur_action), 3);
            end else begin
                step();
            end
            if (k == 31) begin
                check("punch_t31_action", int'(cur_action), 3);
                check("punch_t31_frame", int'(cur_frame), 3);
                check("punch_t31_busy", int'(act_busy), 1);
            end
        end
        check("punch_end_action", int'(cur_action), 0);
        check("punch_end_frame", int'(cur_frame), 0);
        check("punch_end_busy", int'(act_busy), 0);

        // Request and tick together at frame 2, hold 7.
        rst = 1'b1; step(); rst = 1'b0; step();
        ticks(23);
        check("race_pre_frame", int'(cur_frame), 2);
        act_req = 1'b1; act_code = 3'd1; frame_tick = 1'b1; step();
        act_req = 1'b0; frame_tick = 1'b0;
        check("race_action", int'(cur_action), 1);
        check("race_frame", int'(cur_frame), 0);
        ticks(7);  check("race_hold_t7", int'(cur_frame), 0);
        ticks(1);  check("race_hold_t8", int'(cur_frame), 1);

        // Reset during a one-shot at frame 2 with an opaque pixel in flight.
        act_req = 1'b1; act_code = 3'd3; step(); act_req = 1'b0;
        ticks(16);
        check("abort_pre_frame", int'(cur_frame), 2);
        check("abort_pre_busy", int'(act_busy), 1);
        rom_mode = 1'b1; fixed_word = 16'h0000;
        hcount = 10'd110; vcount = 10'd60; pix_valid = 1'b1;
        step(); step();
        check("abort_pre_pix_on", int'(pix_on), 1);
        rst = 1'b1; step(); rst = 1'b0;
        check("abort_busy", int'(act_busy), 0);
        check("abort_action", int'(cur_action), 0);
        check("abort_frame", int'(cur_frame), 0);
        check("abort_pix_on", int'(pix_on), 0);
        check("abort_pix_valid_o", int'(pix_valid_o), 0);
        pix_valid = 1'b0; step(); step();

        // Vector table: fixed ROM words, mirroring and box edges.
        for (int i = 0; i < 20; i++) begin
            fixed_word  = vecs[i].word;
            facing_left = vecs[i].face;
            hcount = 10'(vecs[i].hx); vcount = 10'd55; pix_valid = 1'b1;
            step();
            pix_valid = 1'b0;
            step();
            check($sformatf("vec%0d_pix_on", i), int'(pix_on), int'(vecs[i].exp_on));
        end
        step(); step();
        rom_mode = 1'b0; facing_left = 1'b0;
        step(); step();

        // Full-rate raster sweep over the box and its border.
        pos_x = 10'd100; pos_y = 10'd50;
        for (int y = 49; y <= 114; y++) begin
            for (int x = 98; x <= 165; x++) begin
                hcount = 10'(x); vcount = 10'(y); pix_valid = 1'b1;
                if (x == 130) facing_left = ~facing_left;
                step();
            end
        end
        pix_valid = 1'b0; step(); step();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0) begin
                pos_x = 10'($urandom_range(0, 1023));
                pos_y = 10'($urandom_range(0, 1023));
            end
            rst         = ($urandom_range(0, 499) == 0);
            frame_tick  = ($urandom_range(0, 3) == 0);
            act_req     = ($urandom_range(0, 15) == 0);
            act_code    = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0) facing_left = ~facing_left;
            pix_valid   = ($urandom_range(0, 9) != 0);
            hcount      = 10'(int'(pos_x) + int'($urandom_range(0, 71)) - 4);
            vcount      = 10'(int'(pos_y) + int'($urandom_range(0, 71)) - 4);
            step();
        end
        rst = 1'b0; frame_tick = 1'b0; act_req = 1'b0; pix_valid = 1'b0;
        step(); step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sprite_anim_fetch.md
Name: sprite_anim_fetch

Overview:
Parametrised sprite animation and pixel-fetch engine for one fighter.
- Holds the current action and animation frame, and steps frames on a frame tick.
- Handles looping actions (stay, cross) and one-shot actions (punch, kick), with a request/busy handshake.
- Turns raster coordinates into a bitmap-ROM row address, applies horizontal mirroring and integer scaling, and returns a pipelined opaque flag.
- Sits between the VGA timing generator and the per-channel bitmap ROMs.

Parameters:
- SPR_W, 16, sprite width in pixels; equals the ROM word width.
- SPR_H, 16, sprite height in rows (power of 2).
- ACT_BITS, 3, action-code width.
- FRM_BITS, 3, frame-index width.
- NUM_FRAMES, 4, frames per action; 1..2^FRM_BITS.
- FRAME_HOLD, 8, frame ticks per animation frame; >=1.
- SCALE_SHIFT, 2, each sprite pixel covers 2^SCALE_SHIFT x 2^SCALE_SHIFT screen pixels.
- ONESHOT_MASK, 8'b00011000, bit a = 1 means action a is one-shot.
- COORD_W, 10, raster coordinate width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- frame_tick  in  1  one-cycle pulse per video frame.
- act_req  in  1  action request strobe.
- act_code  in  ACT_BITS  requested action.
- act_busy  out  1  high while a one-shot plays.
- facing_left  in  1  mirror sprite horizontally.
- pos_x  in  COORD_W  sprite top-left x on screen.
- pos_y  in  COORD_W  sprite top-left y on screen.
- hcount  in  COORD_W  raster x.
- vcount  in  COORD_W  raster y.
- pix_valid  in  1  raster coordinate valid.
- rom_addr  out  log2(SPR_H)+ACT_BITS+FRM_BITS  ROM address, arranged as {row, action, frame}.
- rom_data  in  SPR_W  ROM word, returned 1 cycle after rom_addr.
- pix_on  out  1  sprite pixel is opaque.
- pix_valid_o  out  1  pix_valid delayed to align with pix_on.
- cur_action  out  ACT_BITS  current action.
- cur_frame  out  FRM_BITS  current frame.

Behaviour:
- Reset values: cur_action=0 (stay), cur_frame=0, hold counter=0, state=LOOP, act_busy=0, rom_addr=0, pix_on=0, pix_valid_o=0, all pipeline registers cleared. Reset mid-one-shot aborts to LOOP with action 0.
- Two-state FSM, LOOP and ONESHOT.
- LOOP:
  - act_req with act_code != cur_action: load the action and set frame=0, hold=0.
  - If ONESHOT_MASK[act_code]=1, go to ONESHOT and set act_busy=1 the next cycle.
  - act_req with the same looping code is ignored; the frame keeps running.
- ONESHOT:
  - act_req is ignored (dropped, not queued).
  - After frame NUM_FRAMES-1 completes its hold, return to LOOP with action 0, frame 0, and act_busy=0 on the same edge.
- Frame stepping: on frame_tick, hold increments. When hold reaches FRAME_HOLD-1, hold clears and the frame advances.
  - In LOOP the frame wraps NUM_FRAMES-1 -> 0.
  - act_req and frame_tick in the same cycle: act_req wins; the new action starts at frame 0, hold 0, and that tick is discarded.
- Pixel pipeline:
  - Stage 0 (comb): dx = hcount - pos_x, dy = vcount - pos_y, both modulo 2^COORD_W. in_box = pix_valid && dx < SPR_W<<SCALE_SHIFT && dy < SPR_H<<SCALE_SHIFT. Negative differences wrap large and fall outside the box.
  - Stage 1 (registered): rom_addr = {dy>>SCALE_SHIFT, cur_action, cur_frame}. Also registered: col = dx>>SCALE_SHIFT, in_box, facing_left, pix_valid.
  - Stage 2 (registered): bit index = facing_left ? col : SPR_W-1-col, so unmirrored column 0 is the MSB. pix_on = in_box && (rom_data[bit]==0), since a 0 bit means body/opaque. pix_valid_o = delayed pix_valid.
  - Latency from hcount/vcount/pix_valid to pix_on/pix_valid_o is exactly 2 cycles, full throughput.
- Action and frame changes take effect on the next pixel entering stage 1; tearing mid-frame is acceptable because frame_tick is issued during blanking.
- Pixels outside the box give pix_on=0 regardless of rom_data. rom_addr still updates, and its value is don't-care.

Test Plan:
- Reset, then 40 frame_ticks with FRAME_HOLD=8 and NUM_FRAMES=4 -> cur_frame steps every 8 ticks: 0,1,2,3,0; act_busy stays 0.
- act_req act_code=3 (punch) -> act_busy=1 one cycle later. After 32 ticks, cur_action=0, cur_frame=0, act_busy=0. An act_req=4 issued at tick 10 is ignored.
- act_req=1 and frame_tick in the same cycle while at frame 2, hold 7 -> cur_action=1, cur_frame=0, hold=0.
- pos=(100,50), SCALE_SHIFT=2, raster (100,50)..(163,113) -> rom_addr row = (vcount-50)>>2. pix_on matches the ROM bit with the MSB at x=100..103, 2 cycles later. x=99 and x=164 -> pix_on=0.
- Row word 16'b1111110000111111 with facing_left=0 and then 1 -> opaque screen columns 6..9 in both cases (symmetric). Word 16'b1111100000000111 -> opaque columns 5..12 unmirrored, 3..10 mirrored.
- Assert rst during a one-shot at frame 2 -> next cycle act_busy=0, cur_action=0, cur_frame=0, pix_on=0, pix_valid_o=0.
